// File: rtl/tlp_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tlp_tx_scheduler
//
// Purpose:
//   Transmit-side scheduler between the transaction layer and the 32-bit TLP
//   link. It picks one of two request sources round-robin: writes (address,
//   ID, 32 B payload) or reads (address, ID). It turns the granted request
//   into a stream of dwords and keeps the TLP until the link partner
//   acknowledges it. On nack or on an ack timeout the whole TLP is sent again.
//   After MAX_REPLAY replays the TLP is dropped and a sticky error is flagged.
//
// Handshake semantics (every valid/ready pair in this block):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. A source that raises valid keeps valid high, and keeps its payload
//   stable, until that transfer. Ready may depend on valid combinationally.
//   The TLP stream obeys the same rule: while tlp_valid && !tlp_ready,
//   tlp_data holds its value and tlp_valid stays high.
//
// Ports:
//   clk, rst_n        clock; reset is asynchronous and active-HIGH (asserted
//                     while rst_n = 1).
//   wr_req_*          write request channel (valid/ready, addr, id, 256-bit
//                     payload; dword k = bits [32k+31:32k]).
//   rd_req_*          read request channel (valid/ready, addr, id).
//   tlp_data/valid/ready  outgoing TLP dword stream.
//   ack, nack         link response for the outstanding TLP. They count only
//                     in WAIT_ACK. If both are high, the cycle is a nack.
//   seq_num           sequence number of the current or next TLP.
//   busy              scheduler is not idle.
//   replay_err        sticky; set when a TLP is dropped after MAX_REPLAY
//                     replays.
//   dbg_state         current FSM state (IDLE=0, HDR=1, DATA=2, WAIT_ACK=3).
// -----------------------------------------------------------------------------
module tlp_tx_scheduler #(
  parameter int ADDR_WIDTH  = 64,
  parameter int ID_WIDTH    = 4,
  parameter int ACK_TIMEOUT = 256,
  parameter int MAX_REPLAY  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req_valid,
  output logic                  wr_req_ready,
  input  logic [ADDR_WIDTH-1:0] wr_req_addr,
  input  logic [ID_WIDTH-1:0]   wr_req_id,
  input  logic [255:0]          wr_req_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic [ID_WIDTH-1:0]   rd_req_id,
  output logic [31:0]           tlp_data,
  output logic                  tlp_valid,
  input  logic                  tlp_ready,
  input  logic                  ack,
  input  logic                  nack,
  output logic [7:0]            seq_num,
  output logic                  busy,
  output logic                  replay_err,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  // The timer only has to reach ACK_TIMEOUT-1.
  // The replay counter only has to reach MAX_REPLAY.
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int RW = (MAX_REPLAY > 0) ? $clog2(MAX_REPLAY + 1) : 1;

  localparam logic [7:0] TLP_LEN = 8'd8;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q,   state_d;
  logic [2:0]    beat_q,    beat_d;     // dword index inside HDR (0..2) or DATA (0..7)
  logic          is_wr_q,   is_wr_d;    // kind of the held TLP
  logic [63:0]   addr_q,    addr_d;     // zero-extended request address
  logic [7:0]    tag_q,     tag_d;      // zero-extended request ID
  logic [255:0]  data_q,    data_d;     // write payload (unused for reads)
  logic          last_wr_q, last_wr_d;  // 1: last grant went to WRITE
  logic [7:0]    seq_q,     seq_d;
  logic [RW-1:0] replay_q,  replay_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic          err_q,     err_d;

  // ---------------------------------------------------------------------------
  // Round-robin grant. It is evaluated every cycle, but ready is only driven
  // in IDLE. Reset leaves last grant = READ, so WRITE wins the first tie.
  // ---------------------------------------------------------------------------
  logic grant_wr;
  logic grant_rd;
  logic in_idle;

  always_comb begin
    in_idle  = (state_q == ST_IDLE);
    grant_wr = wr_req_valid && (!rd_req_valid || !last_wr_q);
    grant_rd = rd_req_valid && !grant_wr;
  end

  assign wr_req_ready = in_idle && grant_wr;
  assign rd_req_ready = in_idle && grant_rd;

  // ---------------------------------------------------------------------------
  // Output dword mux. The dword is a pure function of the registered state and
  // beat. A stalled beat therefore keeps tlp_data stable with no extra holding
  // register.
  // ---------------------------------------------------------------------------
  always_comb begin
    tlp_valid = 1'b0;
    tlp_data  = 32'd0;
    case (state_q)
      ST_HDR: begin
        tlp_valid = 1'b1;
        case (beat_q)
          3'd0:    tlp_data = {{2{is_wr_q}}, 6'b0, seq_q, tag_q, TLP_LEN};
          3'd1:    tlp_data = addr_q[63:32];
          default: tlp_data = addr_q[31:0];
        endcase
      end
      ST_DATA: begin
        tlp_valid = 1'b1;
        tlp_data  = data_q[{beat_q, 5'b0} +: 32];
      end
      default: begin
        tlp_valid = 1'b0;
        tlp_data  = 32'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Retry decision in WAIT_ACK. A nack always forces a retry, even when ack is
  // also high. A timeout counts only when ack did not arrive on that cycle.
  // ---------------------------------------------------------------------------
  logic retry;
  logic replay_left;

  always_comb begin
    retry       = nack || (!ack && (timer_q == TW'(ACK_TIMEOUT - 1)));
    replay_left = (replay_q < RW'(MAX_REPLAY));
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    tag_d     = tag_q;
    data_d    = data_q;
    last_wr_d = last_wr_q;
    seq_d     = seq_q;
    replay_d  = replay_q;
    timer_d   = timer_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (wr_req_ready) begin
          is_wr_d   = 1'b1;
          addr_d    = 64'(wr_req_addr);
          tag_d     = 8'(wr_req_id);
          data_d    = wr_req_data;
          last_wr_d = 1'b1;
          beat_d    = 3'd0;
          state_d   = ST_HDR;
        end else if (rd_req_ready) begin
          is_wr_d   = 1'b0;
          addr_d    = 64'(rd_req_addr);
          tag_d     = 8'(rd_req_id);
          last_wr_d = 1'b0;
          beat_d    = 3'd0;
          state_d   = ST_HDR;
        end
      end

      ST_HDR: begin
        if (tlp_ready) begin
          if (beat_q == 3'd2) begin
            beat_d  = 3'd0;
            state_d = is_wr_q ? ST_DATA : ST_WAIT;
          end else begin
            beat_d  = beat_q + 3'd1;
          end
        end
      end

      ST_DATA: begin
        if (tlp_ready) begin
          if (beat_q == 3'd7) begin
            beat_d  = 3'd0;
            state_d = ST_WAIT;
          end else begin
            beat_d  = beat_q + 3'd1;
          end
        end
      end

      ST_WAIT: begin
        if (retry) begin
          timer_d = '0;
          if (replay_left) begin
            // Send again from the first header dword. seq_num is unchanged,
            // so the replayed dwords are identical to the first send.
            replay_d = replay_q + RW'(1);
            beat_d   = 3'd0;
            state_d  = ST_HDR;
          end else begin
            // Out of replays: drop the TLP and move to the next sequence number.
            err_d    = 1'b1;
            seq_d    = seq_q + 8'd1;
            replay_d = '0;
            state_d  = ST_IDLE;
          end
        end else if (ack) begin
          seq_d    = seq_q + 8'd1;
          replay_d = '0;
          timer_d  = '0;
          state_d  = ST_IDLE;
        end else begin
          timer_d  = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset is asynchronous and active-high on rst_n.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= ST_IDLE;
      beat_q    <= 3'd0;
      is_wr_q   <= 1'b0;
      addr_q    <= 64'd0;
      tag_q     <= 8'd0;
      data_q    <= 256'd0;
      last_wr_q <= 1'b0;
      seq_q     <= 8'd0;
      replay_q  <= '0;
      timer_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
      last_wr_q <= last_wr_d;
      seq_q     <= seq_d;
      replay_q  <= replay_d;
      timer_q   <= timer_d;
      err_q     <= err_d;
    end
  end

  assign seq_num    = seq_q;
  assign busy       = (state_q != ST_IDLE);
  assign replay_err = err_q;
  assign dbg_state  = state_q;

endmodule
